// File: rtl/nv_nvdla_nocif_dram_write_ig_osctl.sv
// Write ingress outstanding-beat controller: gates AW issue against a programmable beat cap.
// Optional stall statistics counter enabled by defining NVDLA_WR_OS_STATS_EN.
module nv_nvdla_nocif_dram_write_ig_osctl #(
  parameter int PD_W = 77
) (
  input  logic            nvdla_core_clk,
  input  logic            nvdla_core_rst,
  input  logic [7:0]      reg2dp_wr_os_cnt,
  input  logic            os_enable,
  input  logic            drain_req,
  output logic            drain_done,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_len,
  input  logic [PD_W-1:0] cmd_pd,
  output logic            aw_valid,
  input  logic            aw_ready,
  output logic [PD_W-1:0] aw_pd,
  input  logic            eg2ig_axi_vld,
  input  logic [1:0]      eg2ig_axi_len,
  output logic [8:0]      os_cnt,
  output logic            os_err,
  output logic            os_idle
`ifdef NVDLA_WR_OS_STATS_EN
  ,
  input  logic            stats_clr,
  output logic [31:0]     os_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] os_cnt_q, os_cnt_d;
  logic       os_err_q, os_err_d;

  logic [9:0] cap_w;
  logic [9:0] need_w;
  logic [9:0] ret_w;
  logic [9:0] total_w;
  logic       allow;
  logic       issue;

  // 10-bit arithmetic so a full 256-beat count plus a 4-beat request cannot wrap
  assign cap_w   = {2'b00, reg2dp_wr_os_cnt} + 10'd1;
  assign need_w  = {8'd0, cmd_len} + 10'd1;
  assign ret_w   = eg2ig_axi_vld ? ({8'd0, eg2ig_axi_len} + 10'd1) : 10'd0;
  assign allow   = (state_q == RUN) && (({1'b0, os_cnt_q} + need_w) <= cap_w);
  assign issue   = aw_valid & aw_ready;
  assign total_w = {1'b0, os_cnt_q} + (issue ? need_w : 10'd0);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q  <= IDLE;
      os_cnt_q <= 9'd0;
      os_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      os_cnt_q <= os_cnt_d;
      os_err_q <= os_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (os_enable && !drain_req) state_d = RUN;
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if ((os_cnt_q == 9'd0) && !issue) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    aw_valid   = cmd_valid & allow;
    cmd_ready  = aw_ready & allow;
    aw_pd      = cmd_pd;
    drain_done = (state_q == DRAIN) && (os_cnt_q == 9'd0) && !issue;
    os_idle    = (state_q == IDLE);
    os_cnt     = os_cnt_q;
    os_err     = os_err_q;
  end

  // Returns exceeding what is outstanding clamp to zero and latch the error
  always_comb begin
    os_err_d = os_err_q;
    if (ret_w > total_w) begin
      os_cnt_d = 9'd0;
      os_err_d = 1'b1;
    end else begin
      os_cnt_d = 9'(total_w - ret_w);
    end
  end

`ifdef NVDLA_WR_OS_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      stall_cnt_d = 32'd0;
    end else if ((state_q == RUN) && cmd_valid && !allow && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) stall_cnt_q <= 32'd0;
    else                stall_cnt_q <= stall_cnt_d;
  end

  assign os_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_nv_nvdla_nocif_dram_write_ig_osctl.sv
// Directed table-driven bench for the write ingress outstanding-beat controller.
// Stats checks are compiled in only when NVDLA_WR_OS_STATS_EN is defined.
module tb_nv_nvdla_nocif_dram_write_ig_osctl;

  localparam int PD_W = 77;

  logic            clk;
  logic            rst;
  logic [7:0]      reg2dp_wr_os_cnt;
  logic            os_enable;
  logic            drain_req;
  logic            drain_done;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_len;
  logic [PD_W-1:0] cmd_pd;
  logic            aw_valid;
  logic            aw_ready;
  logic [PD_W-1:0] aw_pd;
  logic            eg2ig_axi_vld;
  logic [1:0]      eg2ig_axi_len;
  logic [8:0]      os_cnt;
  logic            os_err;
  logic            os_idle;
`ifdef NVDLA_WR_OS_STATS_EN
  logic            stats_clr;
  logic [31:0]     os_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  nv_nvdla_nocif_dram_write_ig_osctl #(.PD_W(PD_W)) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .reg2dp_wr_os_cnt (reg2dp_wr_os_cnt),
    .os_enable        (os_enable),
    .drain_req        (drain_req),
    .drain_done       (drain_done),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_len          (cmd_len),
    .cmd_pd           (cmd_pd),
    .aw_valid         (aw_valid),
    .aw_ready         (aw_ready),
    .aw_pd            (aw_pd),
    .eg2ig_axi_vld    (eg2ig_axi_vld),
    .eg2ig_axi_len    (eg2ig_axi_len),
    .os_cnt           (os_cnt),
    .os_err           (os_err),
    .os_idle          (os_idle)
`ifdef NVDLA_WR_OS_STATS_EN
    ,
    .stats_clr        (stats_clr),
    .os_stall_cnt     (os_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       drq;
    logic [7:0] cfg;
    logic       cv;
    logic [1:0] clen;
    logic       ar;
    logic       rv;
    logic [1:0] rlen;
    logic       e_awv;
    logic       e_crdy;
    logic       e_dd;
    logic       e_idle;
    logic [8:0] e_cnt;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    os_enable        = v.en;
    drain_req        = v.drq;
    reg2dp_wr_os_cnt = v.cfg;
    cmd_valid        = v.cv;
    cmd_len          = v.clen;
    aw_ready         = v.ar;
    eg2ig_axi_vld    = v.rv;
    eg2ig_axi_len    = v.rlen;
    cmd_pd           = {$urandom, $urandom, $urandom};
  endtask

  task automatic check_output(input int idx, input vec_t v);
    check_value($sformatf("v%0d aw_valid", idx), 32'(aw_valid), 32'(v.e_awv));
    check_value($sformatf("v%0d cmd_ready", idx), 32'(cmd_ready), 32'(v.e_crdy));
    check_value($sformatf("v%0d drain_done", idx), 32'(drain_done), 32'(v.e_dd));
    check_value($sformatf("v%0d os_idle", idx), 32'(os_idle), 32'(v.e_idle));
    check_value($sformatf("v%0d os_cnt", idx), 32'(os_cnt), 32'(v.e_cnt));
    check_value($sformatf("v%0d os_err", idx), 32'(os_err), 32'(v.e_err));
    checks++;
    if (aw_pd !== cmd_pd) begin
      errors++;
      $display("[TB] FAIL v%0d aw_pd: got %h expected %h", idx, aw_pd, cmd_pd);
    end
  endtask

  initial begin
    // Each record: inputs driven this cycle, then outputs expected before the next edge
    //                en  drq cfg   cv clen ar rv rlen awv crdy dd idle cnt  err
    vecs.push_back('{1'b0,1'b0,8'd7,1'b1,2'd1,1'b1,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b1,9'd0,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b0,2'd1,1'b1,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b1,9'd0,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b1,2'd1,1'b1,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,9'd0,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b1,2'd1,1'b1,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,9'd2,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b1,2'd1,1'b1,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,9'd4,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b1,2'd1,1'b1,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,9'd6,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b1,2'd1,1'b1,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0,9'd8,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b1,2'd1,1'b1,1'b1,2'd1, 1'b0,1'b0,1'b0,1'b0,9'd8,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b1,2'd1,1'b1,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,9'd6,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b0,2'd3,1'b1,1'b1,2'd3, 1'b0,1'b0,1'b0,1'b0,9'd8,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b1,2'd3,1'b1,1'b1,2'd3, 1'b1,1'b1,1'b0,1'b0,9'd4,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b0,2'd0,1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0,9'd4,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b1,2'd0,1'b0,1'b0,2'd0, 1'b1,1'b0,1'b0,1'b0,9'd4,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd2,1'b1,2'd0,1'b1,1'b1,2'd1, 1'b0,1'b0,1'b0,1'b0,9'd4,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd2,1'b1,2'd0,1'b1,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,9'd2,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b0,2'd0,1'b0,1'b1,2'd0, 1'b0,1'b0,1'b0,1'b0,9'd3,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b0,2'd0,1'b0,1'b1,2'd3, 1'b0,1'b0,1'b0,1'b0,9'd2,1'b0});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b0,2'd0,1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0,9'd0,1'b1});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b1,2'd3,1'b1,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,9'd0,1'b1});
    vecs.push_back('{1'b1,1'b0,8'd7,1'b1,2'd0,1'b1,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,9'd4,1'b1});
    vecs.push_back('{1'b1,1'b1,8'd7,1'b0,2'd0,1'b1,1'b0,2'd0, 1'b0,1'b1,1'b0,1'b0,9'd5,1'b1});
    vecs.push_back('{1'b1,1'b1,8'd7,1'b1,2'd0,1'b1,1'b1,2'd2, 1'b0,1'b0,1'b0,1'b0,9'd5,1'b1});
    vecs.push_back('{1'b1,1'b1,8'd7,1'b1,2'd0,1'b1,1'b1,2'd1, 1'b0,1'b0,1'b0,1'b0,9'd2,1'b1});
    vecs.push_back('{1'b1,1'b1,8'd7,1'b1,2'd0,1'b1,1'b0,2'd0, 1'b0,1'b0,1'b1,1'b0,9'd0,1'b1});
    vecs.push_back('{1'b1,1'b1,8'd7,1'b1,2'd0,1'b1,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b1,9'd0,1'b1});
    vecs.push_back('{1'b0,1'b0,8'd7,1'b1,2'd0,1'b1,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b1,9'd0,1'b1});

    rst              = 1'b1;
    reg2dp_wr_os_cnt = 8'd7;
    os_enable        = 1'b1;
    drain_req        = 1'b0;
    cmd_valid        = 1'b1;
    cmd_len          = 2'd0;
    cmd_pd           = '0;
    aw_ready         = 1'b1;
    eg2ig_axi_vld    = 1'b0;
    eg2ig_axi_len    = 2'd0;
`ifdef NVDLA_WR_OS_STATS_EN
    stats_clr        = 1'b0;
`endif

    // Reset state with upstream requests pending
    #12;
    check_value("reset os_cnt", 32'(os_cnt), 32'd0);
    check_value("reset os_err", 32'(os_err), 32'd0);
    check_value("reset os_idle", 32'(os_idle), 32'd1);
    check_value("reset aw_valid", 32'(aw_valid), 32'd0);
    check_value("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check_value("reset drain_done", 32'(drain_done), 32'd0);
    os_enable = 1'b0;
    step();
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output(i, vecs[i]);
      step();
    end

    // Full 256-beat cap: fill to 256 and confirm no wrap lets another beat through
    os_enable        = 1'b1;
    drain_req        = 1'b0;
    reg2dp_wr_os_cnt = 8'd255;
    cmd_valid        = 1'b0;
    step();
    cmd_valid = 1'b1;
    cmd_len   = 2'd3;
    aw_ready  = 1'b1;
    for (int k = 0; k < 64; k++) step();
    cmd_len = 2'd0;
    @(negedge clk);
    check_value("cap256 os_cnt", 32'(os_cnt), 32'd256);
    check_value("cap256 aw_valid", 32'(aw_valid), 32'd0);
    check_value("cap256 cmd_ready", 32'(cmd_ready), 32'd0);
    step();

`ifdef NVDLA_WR_OS_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check_value("stall_cnt 10", os_stall_cnt, 32'd10);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check_value("stall_cnt clr", os_stall_cnt, 32'd0);
`endif

    // Asynchronous reset mid-operation discards the count without a drain pulse
    #2;
    rst = 1'b1;
    #1;
    check_value("midrst os_cnt", 32'(os_cnt), 32'd0);
    check_value("midrst os_err", 32'(os_err), 32'd0);
    check_value("midrst os_idle", 32'(os_idle), 32'd1);
    check_value("midrst aw_valid", 32'(aw_valid), 32'd0);
    check_value("midrst cmd_ready", 32'(cmd_ready), 32'd0);
    check_value("midrst drain_done", 32'(drain_done), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_value("post-rst os_idle", 32'(os_idle), 32'd1);
    check_value("post-rst os_cnt", 32'(os_cnt), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
